// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU execute stage and register file.
// Opcodes, FSM encoding and default datapath widths.
package mcpu_pkg;

    localparam int DEFAULT_WORD_SIZE    = 16;
    localparam int DEFAULT_OPERAND_SIZE = 4;
    localparam int DEFAULT_OPCODE_WIDTH = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] REGSETCMD_NONE = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        WB   = 2'b11
    } state_e;

endpackage

// File: rtl/mcpu_shiftadd_mul.sv
// Iterative shift-add multiplier: one partial product per cycle for WORD_SIZE cycles.
// done_o is asserted during the final iteration with the full product on product_o.
module mcpu_shiftadd_mul
    import mcpu_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [WORD_SIZE-1:0]   multiplicand_i,
    input  logic [WORD_SIZE-1:0]   multiplier_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2*WORD_SIZE-1:0] product_o
);

    localparam int CNT_W = $clog2(WORD_SIZE);

    logic [2*WORD_SIZE-1:0] mcand_q;
    logic [2*WORD_SIZE-1:0] acc_q;
    logic [2*WORD_SIZE-1:0] acc_d;
    logic [WORD_SIZE-1:0]   mplier_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   active_q;
    logic                   last_iter;

    assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign last_iter = active_q && (cnt_q == CNT_W'(WORD_SIZE - 1));
    assign busy_o    = active_q;
    assign done_o    = last_iter;
    assign product_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i && !active_q) begin
            // NOTE: non-blocking (<=) throughout so every register samples pre-edge values.
            mcand_q  <= {{WORD_SIZE{1'b0}}, multiplicand_i};
            acc_q    <= '0;
            mplier_q <= multiplier_i;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last_iter) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mcpu_alu_exec.sv
// MCPU execute stage: single-pass logic/shift ops, iterative MUL, registered writeback.
// Define MCPU_ALU_B2B_EN to accept a new issue during the WB cycle (back-to-back).
module mcpu_alu_exec
    import mcpu_pkg::*;
#(
    parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int OPERAND_SIZE = DEFAULT_OPERAND_SIZE,
    parameter int OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH,
    parameter int SHAMT_WIDTH  = $clog2(WORD_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [OPERAND_SIZE-1:0] dst_in,
    input  logic [WORD_SIZE-1:0]    alu1,
    input  logic [WORD_SIZE-1:0]    alu2,
    output logic                    busy,
    output logic [WORD_SIZE-1:0]    datatoload,
    output logic [OPERAND_SIZE-1:0] op3,
    output logic                    regsetwb,
    output logic [1:0]              regsetcmd,
    output logic                    zero,
    output logic                    carry
);

    state_e                  state_q, state_d;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [OPERAND_SIZE-1:0] dst_q;
    logic [WORD_SIZE-1:0]    a_q, b_q;
    logic [WORD_SIZE-1:0]    datatoload_q, datatoload_d;
    logic [OPERAND_SIZE-1:0] op3_q, op3_d;
    logic                    zero_q, zero_d;
    logic                    carry_q, carry_d;
    logic                    regsetwb_q;
    logic                    accept;

    logic                    mul_start, mul_busy, mul_done;
    logic [2*WORD_SIZE-1:0]  mul_product;

    logic [WORD_SIZE-1:0]    alu_res;
    logic                    alu_c;
    logic [WORD_SIZE:0]      wide;
    logic [SHAMT_WIDTH-1:0]  shamt;

`ifdef MCPU_ALU_B2B_EN
    assign accept = start && ((state_q == IDLE) || (state_q == WB));
    assign busy   = (state_q != IDLE) && (state_q != WB);
`else
    assign accept = start && (state_q == IDLE);
    assign busy   = (state_q != IDLE);
`endif

    assign datatoload = datatoload_q;
    assign op3        = op3_q;
    assign zero       = zero_q;
    assign carry      = carry_q;
    assign regsetwb   = regsetwb_q;
    assign regsetcmd  = REGSETCMD_NONE;

    // Shifts run one bit wider so the last bit shifted out lands in wide[WORD_SIZE] / wide[0].
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        shamt   = b_q[SHAMT_WIDTH-1:0];
        case (opcode_q)
            OP_ADD: begin
                wide    = {1'b0, a_q} + {1'b0, b_q};
                alu_res = wide[WORD_SIZE-1:0];
                alu_c   = wide[WORD_SIZE];
            end
            OP_SUB: begin
                wide    = {1'b0, a_q} - {1'b0, b_q};
                alu_res = wide[WORD_SIZE-1:0];
                alu_c   = wide[WORD_SIZE];
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                wide    = {1'b0, a_q} << shamt;
                alu_res = wide[WORD_SIZE-1:0];
                alu_c   = wide[WORD_SIZE];
            end
            OP_SHR: begin
                wide    = {a_q, 1'b0} >> shamt;
                alu_res = wide[WORD_SIZE:1];
                alu_c   = wide[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first; a branch that skips one would infer a latch.
        state_d      = state_q;
        datatoload_d = datatoload_q;
        op3_d        = op3_q;
        zero_d       = zero_q;
        carry_d      = carry_q;
        mul_start    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (opcode == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                datatoload_d = alu_res;
                carry_d      = alu_c;
                zero_d       = (alu_res == '0);
                op3_d        = dst_q;
                state_d      = WB;
            end
            MUL: begin
                mul_start = !mul_busy;
                if (mul_done) begin
                    datatoload_d = mul_product[WORD_SIZE-1:0];
                    carry_d      = |mul_product[2*WORD_SIZE-1:WORD_SIZE];
                    zero_d       = (mul_product[WORD_SIZE-1:0] == '0);
                    op3_d        = dst_q;
                    state_d      = WB;
                end
            end
            WB: begin
                if (accept) begin
                    state_d = (opcode == OP_MUL) ? MUL : EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            opcode_q     <= '0;
            dst_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            datatoload_q <= '0;
            op3_q        <= '0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            regsetwb_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            datatoload_q <= datatoload_d;
            op3_q        <= op3_d;
            zero_q       <= zero_d;
            carry_q      <= carry_d;
            // Strobe trails WB by one edge so the register file sees settled results.
            regsetwb_q   <= (state_q == WB);
            if (accept) begin
                opcode_q <= opcode;
                dst_q    <= dst_in;
                a_q      <= alu1;
                b_q      <= alu2;
            end
        end
    end

    mcpu_shiftadd_mul #(
        .WORD_SIZE (WORD_SIZE)
    ) u_mul (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (mul_start),
        .multiplicand_i (a_q),
        .multiplier_i   (b_q),
        .busy_o         (mul_busy),
        .done_o         (mul_done),
        .product_o      (mul_product)
    );

endmodule
